pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core. It combines stall requests from the decode and execute stages with a load-use interlock that tracks the load destination currently in EX. From these it drives the per-stage stall vector, and it runs the exception flush sequence that redirects fetch. It sits beside the pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the PC unit, and takes its hazard inputs directly from the decode outputs.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_ld_use_tracker.sv | 54 +++++
 rtl/pipe_ctrl.sv | 97 +++++++++
 tb/tb_pipe_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: bus widths,
// stall-vector encodings and the controller FSM state type.
package pipe_ctrl_pkg;
  localparam int RegAddrBus  = 5;
  localparam int InstAddrBus = 32;
  localparam int StallBus    = 6;

  // Stall vector bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [StallBus-1:0] STALL_NONE = 6'b000000;
  localparam logic [StallBus-1:0] STALL_ID   = 6'b000111;
  localparam logic [StallBus-1:0] STALL_EX   = 6'b001111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pipe_state_e;
endpackage

// File: rtl/pipe_ctrl_ld_use_tracker.sv
// Tracks the load destination currently in EX and flags a load-use hazard
// against the source registers being read in ID.
module pipe_ctrl_ld_use_tracker
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  stall_ex_i,
  input  logic                  stall_id_i,
  input  logic                  id_reg1_read,
  input  logic [RegAddrBus-1:0] id_reg1_addr,
  input  logic                  id_reg2_read,
  input  logic [RegAddrBus-1:0] id_reg2_addr,
  input  logic                  id_wreg,
  input  logic [RegAddrBus-1:0] id_wd,
  input  logic                  id_is_load,
  output logic                  load_use_o
);
  logic                  ex_ld_v_q, ex_ld_v_d;
  logic [RegAddrBus-1:0] ex_ld_wd_q, ex_ld_wd_d;

  always_comb begin
    ex_ld_v_d  = ex_ld_v_q;
    ex_ld_wd_d = ex_ld_wd_q;
    if (flush_i) begin
      ex_ld_v_d  = 1'b0;
      ex_ld_wd_d = '0;
    end else if (stall_ex_i) begin
      ex_ld_v_d  = ex_ld_v_q;
    end else if (stall_id_i) begin
      // ID held while EX advances: a bubble moves into EX.
      ex_ld_v_d  = 1'b0;
    end else begin
      ex_ld_v_d  = id_is_load & id_wreg;
      ex_ld_wd_d = id_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ld_v_q  <= 1'b0;
      ex_ld_wd_q <= '0;
    end else begin
      ex_ld_v_q  <= ex_ld_v_d;
      ex_ld_wd_q <= ex_ld_wd_d;
    end
  end

  // r0 is hardwired to zero, so it never creates a real dependency.
  assign load_use_o = ex_ld_v_q && (ex_ld_wd_q != '0) &&
                      ((id_reg1_read && (id_reg1_addr == ex_ld_wd_q)) ||
                       (id_reg2_read && (id_reg2_addr == ex_ld_wd_q)));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests with the load-use
// interlock into a per-stage stall vector and sequences exception flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_MAX = 1023,
  parameter int CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   id_reg1_read,
  input  logic [RegAddrBus-1:0]  id_reg1_addr,
  input  logic                   id_reg2_read,
  input  logic [RegAddrBus-1:0]  id_reg2_addr,
  input  logic                   id_wreg,
  input  logic [RegAddrBus-1:0]  id_wd,
  input  logic                   id_is_load,
  input  logic                   excp_req,
  input  logic [InstAddrBus-1:0] excp_pc,
  output logic [StallBus-1:0]    stall_o,
  output logic                   flush_o,
  output logic [InstAddrBus-1:0] new_pc_o,
  output logic                   stall_timeout_o,
  output pipe_state_e            state_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_MAX);

  pipe_state_e            state_q;
  logic [InstAddrBus-1:0] new_pc_q;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
  logic                   timeout_q;
  logic                   load_use;
  logic [StallBus-1:0]    stall;
  logic                   in_flush;

  assign in_flush = (state_q == ST_FLUSH);

  pipe_ctrl_ld_use_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (in_flush),
    .stall_ex_i   (stall[3]),
    .stall_id_i   (stall[2]),
    .id_reg1_read (id_reg1_read),
    .id_reg1_addr (id_reg1_addr),
    .id_reg2_read (id_reg2_read),
    .id_reg2_addr (id_reg2_addr),
    .id_wreg      (id_wreg),
    .id_wd        (id_wd),
    .id_is_load   (id_is_load),
    .load_use_o   (load_use)
  );

  // Reset also masks the stall vector so the pipeline sees no holds in reset.
  always_comb begin
    stall = STALL_NONE;
    if (!rst && !in_flush) begin
      if (stallreq_ex)                 stall = STALL_EX;
      else if (stallreq_id || load_use) stall = STALL_ID;
    end
  end

  always_comb begin
    if (in_flush || (stall == STALL_NONE)) stall_cnt_d = '0;
    else if (stall_cnt_q == CNT_MAX)       stall_cnt_d = stall_cnt_q;
    else                                   stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      new_pc_q    <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (excp_req) begin
            state_q  <= ST_FLUSH;
            new_pc_q <= excp_pc;
          end
        end
        default: state_q <= ST_RUN;
      endcase
      stall_cnt_q <= stall_cnt_d;
      if (stall_cnt_d == CNT_MAX) timeout_q <= 1'b1;
    end
  end

  assign stall_o         = stall;
  assign flush_o         = in_flush;
  assign new_pc_o        = new_pc_q;
  assign stall_timeout_o = timeout_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: the driver pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int W = 41; // {flush_state, flush, new_pc[31:0], stall[5:0], timeout}

  logic        clk, rst;
  logic        stallreq_id, stallreq_ex;
  logic        id_reg1_read, id_reg2_read, id_wreg, id_is_load, excp_req;
  logic [4:0]  id_reg1_addr, id_reg2_addr, id_wd;
  logic [31:0] excp_pc;
  logic [5:0]  stall_o;
  logic        flush_o, stall_timeout_o;
  logic [31:0] new_pc_o;
  pipe_state_e state_o;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_chk = 0;
  int           n_fail = 0;

  pipe_ctrl #(.STALL_MAX(8), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
    .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
    .id_wreg(id_wreg), .id_wd(id_wd), .id_is_load(id_is_load),
    .excp_req(excp_req), .excp_pc(excp_pc),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .stall_timeout_o(stall_timeout_o), .state_o(state_o)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic clr_in();
    stallreq_id = 0; stallreq_ex = 0; excp_req = 0; excp_pc = '0;
    id_reg1_read = 0; id_reg1_addr = '0; id_reg2_read = 0; id_reg2_addr = '0;
    id_wreg = 0; id_wd = '0; id_is_load = 0;
  endtask

  task automatic ld(input logic [4:0] wd);
    clr_in();
    id_is_load = 1; id_wreg = 1; id_wd = wd;
  endtask

  // Push the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input logic [5:0] s, input logic f, input logic [31:0] pc,
                     input logic to, input string nm);
    exp_q.push_back({f, f, pc, s, to});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    string nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act   = {state_o == ST_FLUSH, flush_o, new_pc_o, stall_o, stall_timeout_o};
      n_chk++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got {st,fl,pc,stall,to}=%h required %h", nm, act, exp_v);
      end
    end
  end

  initial begin
    clr_in();
    rst = 1;
    stallreq_id = 1; stallreq_ex = 1; excp_req = 1; excp_pc = 32'hdead_beef;
    id_is_load = 1; id_wreg = 1; id_wd = 5'd5; id_reg1_read = 1; id_reg1_addr = 5'd5;
    @(posedge clk); #1;
    cyc(6'b000000, 0, 32'h0, 0, "reset_1");
    cyc(6'b000000, 0, 32'h0, 0, "reset_2");
    rst = 0; clr_in();
    cyc(6'b000000, 0, 32'h0, 0, "idle");

    // load-use on r5 via source 1
    ld(5'd5);                                   cyc(6'b000000, 0, 0, 0, "lw_r5");
    clr_in(); id_reg1_read = 1; id_reg1_addr = 5; id_wreg = 1; id_wd = 7;
                                                cyc(6'b000111, 0, 0, 0, "lu_r5_stall");
                                                cyc(6'b000000, 0, 0, 0, "lu_r5_release");
    clr_in();                                   cyc(6'b000000, 0, 0, 0, "lu_r5_after");
    // r0 never interlocks
    ld(5'd0);                                   cyc(6'b000000, 0, 0, 0, "lw_r0");
    clr_in(); id_reg1_read = 1; id_reg2_read = 1;
                                                cyc(6'b000000, 0, 0, 0, "lu_r0_none");
    // source 2 path, and read-enable gating
    ld(5'd9);                                   cyc(6'b000000, 0, 0, 0, "lw_r9");
    clr_in(); id_reg2_read = 1; id_reg2_addr = 9;
                                                cyc(6'b000111, 0, 0, 0, "lu_r9_src2");
    ld(5'd3);                                   cyc(6'b000000, 0, 0, 0, "lw_r3");
    clr_in(); id_reg1_addr = 3; id_reg2_addr = 3;
                                                cyc(6'b000000, 0, 0, 0, "lu_r3_noread");

    // EX priority for 3 cycles while a load-use is pending; tracker holds
    ld(5'd4);                                   cyc(6'b000000, 0, 0, 0, "lw_r4");
    clr_in(); stallreq_ex = 1; stallreq_id = 1; id_reg1_read = 1; id_reg1_addr = 4;
    for (int i = 0; i < 3; i++)                 cyc(6'b001111, 0, 0, 0, "ex_prio");
    stallreq_ex = 0; stallreq_id = 0;           cyc(6'b000111, 0, 0, 0, "ex_hold_lu");
                                                cyc(6'b000000, 0, 0, 0, "ex_hold_done");

    // exception
    clr_in(); excp_req = 1; excp_pc = 32'h0000_0180;
                                                cyc(6'b000000, 0, 32'h0,   0, "excp_req");
    clr_in();                                   cyc(6'b000000, 1, 32'h180, 0, "excp_flush");
                                                cyc(6'b000000, 0, 32'h180, 0, "excp_resume");

    // exception during stall; second request and load in FLUSH are ignored
    clr_in(); stallreq_id = 1; excp_req = 1; excp_pc = 32'h0000_2000;
                                                cyc(6'b000111, 0, 32'h180,  0, "excp_stall");
    clr_in(); excp_req = 1; excp_pc = 32'h0000_3000; stallreq_ex = 1; stallreq_id = 1;
    id_is_load = 1; id_wreg = 1; id_wd = 6;     cyc(6'b000000, 1, 32'h2000, 0, "flush_ignores");
    clr_in(); id_reg1_read = 1; id_reg1_addr = 6;
                                                cyc(6'b000000, 0, 32'h2000, 0, "flush_clr_trk");

    // reset in the middle of a flush
    clr_in(); excp_req = 1; excp_pc = 32'h0000_0044;
                                                cyc(6'b000000, 0, 32'h2000, 0, "excp_44");
    clr_in(); rst = 1;                          cyc(6'b000000, 1, 32'h44,   0, "rst_in_flush");
    rst = 0;                                    cyc(6'b000000, 0, 32'h0,    0, "rst_flush_out");

    // watchdog with STALL_MAX=8
    clr_in(); stallreq_id = 1;
    for (int k = 1; k <= 10; k++)
      cyc(6'b000111, 0, 32'h0, (k >= 9), $sformatf("wdog_%0d", k));
    clr_in();                                   cyc(6'b000000, 0, 0, 1, "wdog_sticky_1");
                                                cyc(6'b000000, 0, 0, 1, "wdog_sticky_2");
    rst = 1;                                    cyc(6'b000000, 0, 0, 1, "wdog_pre_rst");
    rst = 0;                                    cyc(6'b000000, 0, 0, 0, "wdog_cleared");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
